// File: rtl/bridge_pkg.sv
// Shared types and defaults for the AHB-Lite to APB bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WDATA  = 2'd1,
        ST_SETUP  = 2'd2,
        ST_ACCESS = 2'd3
    } state_e;

    localparam logic [1:0]  HRESP_OKAY          = 2'b00;
    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h8000_0000;
    localparam int          DEFAULT_REGION_LOG2 = 26;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational HADDR to one-hot PSEL decode over NUM_SLAVES equal-size regions.
module apb_addr_decoder
    import bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_SLAVES  = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int                    REGION_LOG2 = DEFAULT_REGION_LOG2
) (
    input  logic [ADDR_WIDTH-1:0] haddr,
    output logic [NUM_SLAVES-1:0] psel
);

    logic [ADDR_WIDTH-1:0] region;
    logic [ADDR_WIDTH-1:0] base_region;

    assign region      = haddr >> REGION_LOG2;
    assign base_region = BASE_ADDR >> REGION_LOG2;

    // Addresses outside every region leave psel all-zero.
    always_comb begin
        psel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            psel[i] = (region == (base_region + ADDR_WIDTH'(i)));
        end
    end

endmodule

// File: rtl/modport_bridge.sv
// AHB-Lite slave to APB master bridge: one SETUP/ACCESS APB transaction per valid AHB transfer.
// state     | meaning
// ST_IDLE   | ready, waiting for a valid address phase
// ST_WDATA  | write data phase, capture HWDATA
// ST_SETUP  | APB setup, PSEL asserted
// ST_ACCESS | APB access, PENABLE high, next address may be accepted
module modport_bridge
    import bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_SLAVES  = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int                    REGION_LOG2 = DEFAULT_REGION_LOG2
) (
    input  logic                  clock,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HSELAPB,
    input  logic                  HREADYin,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYout,
    output logic [1:0]            HRESP,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  hready_q, hready_d;

    logic [NUM_SLAVES-1:0] dec_sel;
    htrans_e               htrans;
    logic                  valid;
    logic                  unused_ctrl;

    assign unused_ctrl = ^{HSIZE, HBURST};
    assign htrans      = htrans_e'(HTRANS);
    assign valid       = HSELAPB & HREADYin & ((htrans == NONSEQ) | (htrans == SEQ));

    apb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR),
        .REGION_LOG2(REGION_LOG2)
    ) u_decoder (
        .haddr(HADDR),
        .psel (dec_sel)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE, ST_ACCESS: begin
                if (valid) begin
                    addr_d  = HADDR;
                    write_d = HWRITE;
                    sel_d   = dec_sel;
                    state_d = HWRITE ? ST_WDATA : ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WDATA: begin
                wdata_d = HWDATA;
                state_d = ST_SETUP;
            end
            ST_SETUP: state_d = ST_ACCESS;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        psel_d    = ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) ? sel_d : '0;
        penable_d = (state_d == ST_ACCESS);
        hready_d  = (state_d == ST_IDLE) || (state_d == ST_ACCESS);
    end

    always_ff @(posedge clock or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            sel_q     <= '0;
            wdata_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            hready_q  <= hready_d;
        end
    end

    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PWDATA    = wdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign HREADYout = hready_q;
    assign HRESP     = HRESP_OKAY;
    assign HRDATA    = ((state_q == ST_ACCESS) && !write_q && (|sel_q)) ? PRDATA : '0;

endmodule

// File: tb/tb_modport_bridge.sv
// Directed, table-driven bench for the AHB-Lite to APB bridge.
module tb_modport_bridge;

    logic        clock = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HSELAPB;
    logic        HREADYin;
    logic [31:0] HRDATA;
    logic        HREADYout;
    logic [1:0]  HRESP;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    modport_bridge dut (
        .clock    (clock),
        .HRESET   (HRESET),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HWDATA   (HWDATA),
        .HSELAPB  (HSELAPB),
        .HREADYin (HREADYin),
        .HRDATA   (HRDATA),
        .HREADYout(HREADYout),
        .HRESP    (HRESP),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA)
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic [3:0]  psel;
        logic [31:0] hrdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        HSELAPB  = 1'b0;
        HTRANS   = 2'd0;
        HREADYin = 1'b1;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_psel"},    32'(PSEL), 32'h0);
        chk({name, "_penable"}, 32'(PENABLE), 32'h0);
        chk({name, "_hready"},  32'(HREADYout), 32'h1);
    endtask

    // Full single transfer: address phase, optional write data phase, SETUP, ACCESS, back to idle.
    task automatic run_xfer(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        HSELAPB  = 1'b1;
        HREADYin = 1'b1;
        HTRANS   = 2'd2;
        HADDR    = v.addr;
        HWRITE   = v.write;
        PRDATA   = v.prdata;
        @(negedge clock);
        chk({tag, "_addr_hready"}, 32'(HREADYout), 32'h1);
        chk({tag, "_addr_psel"},   32'(PSEL), 32'h0);
        step();
        drive_idle();
        HWDATA = v.wdata;
        if (v.write) begin
            @(negedge clock);
            chk({tag, "_wdata_hready"},  32'(HREADYout), 32'h0);
            chk({tag, "_wdata_psel"},    32'(PSEL), 32'h0);
            chk({tag, "_wdata_penable"}, 32'(PENABLE), 32'h0);
            step();
            HWDATA = 32'h0;
        end
        @(negedge clock);
        chk({tag, "_setup_hready"},  32'(HREADYout), 32'h0);
        chk({tag, "_setup_psel"},    32'(PSEL), 32'(v.psel));
        chk({tag, "_setup_penable"}, 32'(PENABLE), 32'h0);
        chk({tag, "_setup_paddr"},   PADDR, v.addr);
        chk({tag, "_setup_pwrite"},  32'(PWRITE), 32'(v.write));
        chk({tag, "_setup_hrdata"},  HRDATA, 32'h0);
        if (v.write) chk({tag, "_setup_pwdata"}, PWDATA, v.wdata);
        step();
        @(negedge clock);
        chk({tag, "_access_hready"},  32'(HREADYout), 32'h1);
        chk({tag, "_access_psel"},    32'(PSEL), 32'(v.psel));
        chk({tag, "_access_penable"}, 32'(PENABLE), 32'h1);
        chk({tag, "_access_paddr"},   PADDR, v.addr);
        chk({tag, "_access_hrdata"},  HRDATA, v.hrdata);
        chk({tag, "_access_hresp"},   32'(HRESP), 32'h0);
        if (v.write) chk({tag, "_access_pwdata"}, PWDATA, v.wdata);
        step();
        @(negedge clock);
        chk_quiet({tag, "_idle"});
        chk({tag, "_idle_paddr_hold"}, PADDR, v.addr);
        chk({tag, "_idle_hrdata"}, HRDATA, 32'h0);
        step();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 32'h0,         4'b0001, 32'h0};
        vecs[1] = '{32'h8400_0004, 1'b0, 32'h0,         32'h1234_5678, 4'b0010, 32'h1234_5678};
        vecs[2] = '{32'h0000_1000, 1'b0, 32'h0,         32'hAAAA_5555, 4'b0000, 32'h0};
        vecs[3] = '{32'h8C00_0020, 1'b1, 32'hCAFE_F00D, 32'h0,         4'b1000, 32'h0};
        vecs[4] = '{32'h8FFF_FFFC, 1'b0, 32'h0,         32'h0BAD_C0DE, 4'b1000, 32'h0BAD_C0DE};
        vecs[5] = '{32'h9000_0000, 1'b0, 32'h0,         32'h5A5A_5A5A, 4'b0000, 32'h0};
        vecs[6] = '{32'h7FFF_FFFC, 1'b1, 32'h1111_2222, 32'h0,         4'b0000, 32'h0};

        HRESET = 1'b1;
        HADDR  = 32'h0;
        HWRITE = 1'b0;
        HSIZE  = 3'd2;
        HBURST = 3'd0;
        HWDATA = 32'h0;
        PRDATA = 32'h0;
        drive_idle();
        #2;
        chk_quiet("reset");
        chk("reset_paddr",  PADDR, 32'h0);
        chk("reset_pwdata", PWDATA, 32'h0);
        chk("reset_pwrite", 32'(PWRITE), 32'h0);
        chk("reset_hrdata", HRDATA, 32'h0);
        chk("reset_hresp",  32'(HRESP), 32'h0);
        step();
        step();
        HRESET = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_xfer(vecs[i], i);

        // INCR4 read burst: next address offered during each ACCESS cycle.
        HSELAPB  = 1'b1;
        HREADYin = 1'b1;
        HWRITE   = 1'b0;
        HBURST   = 3'd3;
        for (int b = 0; b < 4; b++) begin
            HTRANS = (b == 0) ? 2'd2 : 2'd3;
            HADDR  = 32'h8800_0000 + 32'(b * 4);
            PRDATA = 32'hB000_0000 + 32'(b);
            if (b == 0) begin
                @(negedge clock);
                chk("burst_addr_hready", 32'(HREADYout), 32'h1);
            end
            step();
            HREADYin = 1'b0;
            @(negedge clock);
            chk($sformatf("burst%0d_setup_psel", b),    32'(PSEL), 32'h4);
            chk($sformatf("burst%0d_setup_penable", b), 32'(PENABLE), 32'h0);
            chk($sformatf("burst%0d_setup_paddr", b),   PADDR, 32'h8800_0000 + 32'(b * 4));
            chk($sformatf("burst%0d_setup_hready", b),  32'(HREADYout), 32'h0);
            step();
            HREADYin = 1'b1;
            if (b == 3) begin
                HTRANS  = 2'd0;
                HSELAPB = 1'b0;
            end else begin
                HTRANS = 2'd3;
                HADDR  = 32'h8800_0000 + 32'((b + 1) * 4);
            end
            @(negedge clock);
            chk($sformatf("burst%0d_access_penable", b), 32'(PENABLE), 32'h1);
            chk($sformatf("burst%0d_access_hrdata", b),  HRDATA, 32'hB000_0000 + 32'(b));
            chk($sformatf("burst%0d_access_paddr", b),   PADDR, 32'h8800_0000 + 32'(b * 4));
            chk($sformatf("burst%0d_access_hready", b),  32'(HREADYout), 32'h1);
            if (b == 3) begin
                step();
                @(negedge clock);
                chk_quiet("burst_end");
                step();
            end
        end
        drive_idle();
        HBURST = 3'd0;

        // Ignored transfers: IDLE, BUSY, deselected, not ready.
        for (int k = 0; k < 4; k++) begin
            HADDR   = 32'h8000_0040;
            HWRITE  = k[0];
            HSELAPB = (k != 2);
            HTRANS  = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : 2'd2;
            HREADYin = (k != 3);
            step();
            drive_idle();
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                chk_quiet($sformatf("ignore%0d_c%0d", k, c));
                step();
            end
        end

        // Reset asserted while PENABLE is high.
        HSELAPB  = 1'b1;
        HTRANS   = 2'd2;
        HADDR    = 32'h8400_0008;
        HWRITE   = 1'b0;
        PRDATA   = 32'h7777_8888;
        step();
        drive_idle();
        step();
        @(negedge clock);
        chk("prereset_penable", 32'(PENABLE), 32'h1);
        HRESET = 1'b1;
        #1;
        chk_quiet("rst_mid");
        chk("rst_mid_paddr",  PADDR, 32'h0);
        chk("rst_mid_hrdata", HRDATA, 32'h0);
        chk("rst_mid_pwrite", 32'(PWRITE), 32'h0);
        step();
        HRESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk_quiet($sformatf("post_rst_c%0d", c));
            step();
        end

        run_xfer(vecs[1], 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
